// File: rtl/pdm_pkg.sv
// Shared constants and elaboration helpers for the PDM-to-PCM CIC decimator.
// Latency: none; this file holds only functions and constants.
// Backpressure: not applicable.
package pdm_pkg;

   // Ceiling log2, used for elaboration-time widths only.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Accumulator width. The worst-case gain is DECIM**ORDER. The +2 covers
   // the sign bit and the +full-scale code.
   function automatic int acc_w(input int order, input int decim);
      return order * clog2(decim) + 2;
   endfunction

   // PDM bit to integrator step: 1 -> +1, 0 -> -1.
   localparam int PDM_POS = 1;
   localparam int PDM_NEG = -1;

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: registered x - z(previous decimated input), with valid pass-through.
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: none; each word is accepted on the cycle in_valid is high.
// Ports: clk/rst (sync, active-high); in_valid/in_data = decimated word in;
//        out_valid/out_data = difference out, optionally only its top OUT_W bits.
module cic_comb_stage #(
   parameter int W     = 20,
   parameter int OUT_W = W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data
);
   localparam int LOW = W - OUT_W;

   logic [W-1:0]     r_z;
   logic [OUT_W-1:0] r_dat;
   logic             r_vld;
   logic [OUT_W-1:0] w_diff;

   generate
      if (LOW == 0) begin : g_full
         assign w_diff = in_data - r_z;
      end else begin : g_trunc
         // Top OUT_W bits of (x - z). This is the high-part difference minus
         // the borrow out of the discarded low part, so it equals the
         // floor-shifted full difference.
         logic w_borrow;
         assign w_borrow = (in_data[LOW-1:0] < r_z[LOW-1:0]);
         assign w_diff   = in_data[W-1 -: OUT_W] - r_z[W-1 -: OUT_W] - OUT_W'(w_borrow);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_z   <= '0;
         r_dat <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= in_valid;
         if (in_valid) begin
            r_dat <= w_diff;
            r_z   <= in_data;
         end
      end
   end

   assign out_valid = r_vld;
   assign out_data  = r_dat;

endmodule

// File: rtl/pdm_cic_decim.sv
// PDM-to-PCM decimating CIC: integrate per PDM strobe, decimate by DECIM, comb at the output rate.
// Latency: out_valid rises ORDER+1 cycles after the decimating strobe.
// Backpressure: one-entry output register; a word arriving while it is held is dropped and overrun sticks.
// Ports: clk, rst (sync, active-high); in_valid/in_data = PDM bit strobe; sync = realign phase;
//        out_data/out_valid/out_ready = PCM handshake; overrun = sticky drop flag.
module pdm_cic_decim
   import pdm_pkg::*;
#(
   parameter int ORDER    = 3,
   parameter int DECIM    = 64,
   parameter int OUT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_data,
   input  logic                sync,
   output logic [OUT_BITS-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun
);
   localparam int ACC_W = acc_w(ORDER, DECIM);
   localparam int PH_W  = clog2(DECIM);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

   logic [ACC_W-1:0]    r_int     [ORDER];
   logic [ACC_W-1:0]    w_int_nxt [ORDER];
   logic [ACC_W-1:0]    w_step;
   logic [PH_W-1:0]     r_phase;
   logic                w_decim;

   logic                w_cv [ORDER+1];
   logic [ACC_W-1:0]    w_cd [ORDER];
   logic [OUT_BITS-1:0] w_pcm;

   logic [OUT_BITS-1:0] r_out_data;
   logic                r_out_vld;
   logic                r_overrun;

   assign w_step = in_data ? ACC_W'(PDM_POS) : ACC_W'(PDM_NEG);

   // Ripple through the cascade so each stage adds the same-cycle updated
   // output of the stage before it.
   always_comb begin
      logic [ACC_W-1:0] v;
      v = w_step;
      for (int k = 0; k < ORDER; k++) begin
         v            = r_int[k] + v;
         w_int_nxt[k] = v;
      end
   end

   // A strobe that arrives with sync is phase 0, so it can never decimate.
   assign w_decim = in_valid && !sync && (r_phase == PH_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++) r_int[k] <= '0;
         r_phase <= '0;
      end else begin
         if (in_valid) begin
            for (int k = 0; k < ORDER; k++) r_int[k] <= w_int_nxt[k];
         end
         if (sync)
            r_phase <= in_valid ? PH_W'(1) : '0;
         else if (in_valid)
            r_phase <= r_phase + PH_W'(1);
      end
   end

   // The first comb stage takes the updated integrator value directly, so the
   // decimating strobe itself loads comb stage 1.
   assign w_cv[0] = w_decim;
   assign w_cd[0] = w_int_nxt[ORDER-1];

   generate
      for (genvar k = 0; k < ORDER; k++) begin : g_comb
         localparam int OW = (k == ORDER - 1) ? OUT_BITS : ACC_W;
         logic [OW-1:0] w_o;
         cic_comb_stage #(.W(ACC_W), .OUT_W(OW)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (w_cv[k]),
            .in_data   (w_cd[k]),
            .out_valid (w_cv[k+1]),
            .out_data  (w_o)
         );
         // The last stage emits only the top OUT_BITS bits. This is the
         // arithmetic right shift by ACC_W-OUT_BITS.
         if (k == ORDER - 1) begin : g_last
            assign w_pcm = w_o;
         end else begin : g_mid
            assign w_cd[k+1] = w_o;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (w_cv[ORDER]) begin
         if (!r_out_vld || out_ready) begin
            r_out_data <= w_pcm;
            r_out_vld  <= 1'b1;
         end else begin
            r_overrun  <= 1'b1;
         end
      end else if (out_ready) begin
         r_out_vld <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_vld;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Bench for pdm_cic_decim (ORDER=3, DECIM=64, OUT_BITS=16), with strobes every 32 clocks.
// The reference model is the direct convolution of the +-1 input history with the
// cubic boxcar impulse response, evaluated every 64 strobes and then floor-shifted by 4.
module tb_pdm_cic_decim;
   localparam int ORD   = 3;
   localparam int D     = 64;
   localparam int OB    = 16;
   localparam int SHIFT = (ORD * 6 + 2) - OB;
   localparam int HL    = ORD * (D - 1) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_data = 1'b0;
   logic          sync = 1'b0;
   logic          out_ready = 1'b1;
   logic [OB-1:0] out_data;
   logic          out_valid;
   logic          overrun;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int            h [HL];
   int            hist [$];
   int            m_phase;
   bit            model_on;
   logic [OB-1:0] exp_q [$];
   logic [OB-1:0] got_q [$];

   pdm_cic_decim #(.ORDER(ORD), .DECIM(D), .OUT_BITS(OB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .sync      (sync),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (out_valid && out_ready) got_q.push_back(out_data);

   function automatic logic [OB-1:0] conv_word();
      int acc;
      int n;
      acc = 0;
      n = hist.size();
      for (int j = 0; j < HL; j++)
         if (n - 1 - j >= 0) acc += h[j] * hist[n - 1 - j];
      return OB'(acc >>> SHIFT);
   endfunction

   task automatic strobe(input logic b, input logic s);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = b; sync = s;
      if (model_on) begin
         hist.push_back(b ? 1 : -1);
         m_phase = s ? 1 : m_phase + 1;
         if (m_phase == D) begin
            exp_q.push_back(conv_word());
            m_phase = 0;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; sync = 1'b0;
      repeat (30) @(posedge clk);
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1; in_valid = 1'b0; sync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      hist.delete(); exp_q.delete(); got_q.delete();
      m_phase = 0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0000", out_data); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
   endtask

   // mode 0: all ones, mode 1: all zeros, mode 2: alternating 1,0
   task automatic test_constant(input int mode, input logic [OB-1:0] want, input string name);
      logic b;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5 * D; i++) begin
         b = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((i % 2) == 0);
         strobe(b, 1'b0);
      end
      total++;
      if (got_q.size() !== 5) begin bad++; $display("FAIL %s_count: got %0d want 5", name, got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL %s_model word %0d: got %h want %h", name, i, got_q[i], exp_q[i]); end
         if (i >= 3) begin
            total++;
            if (got_q[i] !== want) begin bad++; $display("FAIL %s_steady word %0d: got %h want %h", name, i, got_q[i], want); end
         end
      end
   endtask

   task automatic test_latency();
      int t0;
      int rise;
      int high;
      do_reset();
      out_ready = 1'b1;
      repeat (D - 1) strobe(1'b1, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rise = -1; high = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (rise < 0) rise = cyc;
            high++;
         end
      end
      total++; if (rise !== t0 + 4) begin bad++; $display("FAIL latency_rise: got %0d want %0d", rise - t0, 4); end
      total++; if (high !== 1) begin bad++; $display("FAIL latency_width: got %0d want 1", high); end
   endtask

   task automatic test_random();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4 * D; i++) strobe(1'($urandom_range(0, 1)), 1'b0);
      total++;
      if (got_q.size() !== 4) begin bad++; $display("FAIL random_count: got %0d want 4", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random word %0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < D; i++) strobe(1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: got %b want 1", out_valid); end
      total++; if (out_data !== exp_q[0]) begin bad++; $display("FAIL bp_first_data: got %h want %h", out_data, exp_q[0]); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_early_overrun: got %b want 0", overrun); end
      for (int i = 0; i < D; i++) strobe(1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      total++; if (out_data !== exp_q[0]) begin bad++; $display("FAIL bp_held_data: got %h want %h", out_data, exp_q[0]); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %b want 1", overrun); end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (got_q.size() !== 1) begin bad++; $display("FAIL bp_accept_count: got %0d want 1", got_q.size()); end
      else begin
         total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL bp_accept_data: got %h want %h", got_q[0], exp_q[0]); end
      end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop_valid: got %b want 0", out_valid); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_sticky: got %b want 1", overrun); end
      do_reset();
      @(negedge clk);
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_overrun_clear: got %b want 0", overrun); end
   endtask

   task automatic test_sync();
      int first;
      do_reset();
      model_on = 1'b0;
      out_ready = 1'b1;
      first = -1;
      for (int i = 1; i <= 80; i++) begin
         strobe(1'($urandom_range(0, 1)), 1'(i == 10));
         if (first < 0 && got_q.size() > 0) first = i;
      end
      model_on = 1'b1;
      total++; if (first !== 73) begin bad++; $display("FAIL sync_phase: first word after strobe %0d want 73", first); end
   endtask

   task automatic test_reset_mid();
      int seen;
      do_reset();
      out_ready = 1'b1;
      repeat (2 * D - 1) strobe(1'b1, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL midrst_data: got %h want 0000", out_data); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_word: got %0d valid cycles want 0", seen); end
   endtask

   initial begin
      int tmp [HL];
      for (int n = 0; n < HL; n++) h[n] = 0;
      h[0] = 1;
      repeat (ORD) begin
         for (int n = 0; n < HL; n++) begin
            tmp[n] = 0;
            for (int k = 0; k < D; k++) if (n - k >= 0) tmp[n] += h[n - k];
         end
         for (int n = 0; n < HL; n++) h[n] = tmp[n];
      end
      model_on = 1'b1;
      m_phase = 0;

      test_reset();
      test_constant(0, 16'h4000, "ones");
      test_constant(1, 16'hC000, "zeros");
      test_constant(2, 16'h0000, "alt");
      test_latency();
      test_random();
      test_backpressure();
      test_sync();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pdm_cic_decim.md
# pdm_cic_decim

Decimating CIC filter that turns the 1-bit PDM stream from the side-sync / PDM-sum stage into signed PCM words. Each PDM bit arrives as a single-cycle strobe on the system clock. The block integrates at the PDM rate, decimates by `DECIM`, and combs at the output rate. PCM words leave through a one-entry valid/ready output register toward the sample FIFO / host link.

## Interface
Parameters:
- `ORDER`, 3: number of integrator and comb stages (1..5).
- `DECIM`, 64: decimation ratio; power of two, 4..256.
- `OUT_BITS`, 16: PCM output width; must be ≤ `ACC_W`.
- `ACC_W` (derived, not overridable): `ORDER*log2(DECIM)+2`. Equals 20 for the defaults.

Ports:
- `clk`, in, 1: single system clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: one-cycle strobe marking a new PDM bit.
- `in_data`, in, 1: PDM bit, sampled only when `in_valid` is high. 1 maps to +1, 0 maps to −1.
- `sync`, in, 1: realigns the decimation phase.
- `out_data`, out, `OUT_BITS`: signed two's-complement PCM word.
- `out_valid`, out, 1: `out_data` is held and valid.
- `out_ready`, in, 1: consumer accepts the word.
- `overrun`, out, 1: sticky flag; a decimated word was dropped.

## Operation
- Reset sets every register to 0: integrators, comb delays, comb pipeline, phase counter, `out_data`, `out_valid`, `overrun`.
- Integrators:
  - On each `in_valid`, stage 1 adds ±1.
  - Stage k adds the updated output of stage k−1 in the same cycle.
  - All stages are `ACC_W` wide and wrap modulo 2^`ACC_W`. Wrap is intentional; the combs cancel it.
- Phase counter:
  - Counts `in_valid` strobes 0..`DECIM`−1 and wraps.
  - The strobe on which the counter equals `DECIM`−1 is the decimating strobe. On that strobe the updated last-integrator value is captured into the comb pipeline.
- Comb pipeline:
  - `ORDER` registered stages, one per cycle.
  - Stage k outputs x − z, where z is that stage's own previous decimated input. It then updates z to x.
  - Arithmetic is `ACC_W` wide and wraps.
- Output scaling: `out_data` = final comb value arithmetically shifted right by `ACC_W`−`OUT_BITS`. This keeps the top `OUT_BITS` bits and truncates toward −∞. No saturation is needed: full scale is ±`DECIM`^`ORDER`, which fits in `ACC_W`.
- Output register:
  - When a new word is ready and the register is empty, or is being emptied this cycle (`out_valid && out_ready`), load it and set `out_valid`.
  - If `out_valid` is high and `out_ready` is low, drop the new word, keep the old word and set `overrun`. `overrun` is cleared only by `rst`.
  - `out_data` stays stable while `out_valid` is high and `out_ready` is low.
- `sync`:
  - Clears the phase counter; integrators and combs are untouched.
  - If `sync` and `in_valid` are high in the same cycle, that bit is integrated and counts as phase 0, so the counter becomes 1.
- Reset mid-operation discards any word in the comb pipeline; no output is produced for it.

## Timing
- Integrators and phase counter update in the same cycle as `in_valid`, with zero added latency.
- `out_valid` rises exactly `ORDER`+1 cycles after the decimating strobe: `ORDER` comb cycles plus 1 output-register cycle.
- Input strobes must be at least `ORDER`+2 cycles apart. The PDM clock generator guarantees at least 32. Closer strobes are unsupported and are not detected.
- A handshake completes on a cycle with `out_valid && out_ready`. `out_valid` drops the following cycle unless a new word loads in that same cycle.
- Settling: comb output is exact from the (`ORDER`+1)-th decimated word after reset.

## Structure
- Shared package `pdm_pkg` holds:
  - the `clog2` helper and the `ACC_W` formula;
  - the ±1 input mapping constants.
- Sub-module `cic_comb_stage`, instantiated `ORDER` times. It contains:
  - the registered difference;
  - the delay register;
  - valid pass-through.
- Integrators, phase counter and output register stay in the top module.

## Test plan
All scenarios use defaults (`ORDER`=3, `DECIM`=64, `OUT_BITS`=16) with strobes every 32 clocks and `out_ready`=1 unless stated.
- All-ones stream -> from the 4th word on, `out_data`=16'h4000 (+2^18 >> 4).
- All-zeros stream -> from the 4th word on, `out_data`=16'hC000.
- Alternating 1,0 stream -> from the 4th word on, `out_data`=0.
- Latency: the 64th strobe is at cycle T -> `out_valid` rises at T+4 and stays high exactly 1 cycle.
- Backpressure: hold `out_ready`=0 across two decimations -> first word held unchanged and `overrun`=1. Raise `out_ready` -> first word accepted; `overrun` stays 1 until `rst`.
- Sync and reset:
  - Assert `sync` with strobe 10 -> the next word appears 63 strobes later.
  - Assert `rst` 2 cycles after a decimating strobe -> no `out_valid`, and all outputs are 0 the next cycle.
